// File: rtl/demux_pkg.sv
// Shared types and helpers for the registered 1-to-4 demultiplexer.
// Channel count, channel index type and one-hot decode.
package demux_pkg;

  localparam int NCH   = 4;
  localparam int W_DEF = 2;

  typedef logic [1:0] sel_t;

  function automatic logic [NCH-1:0] onehot(
    input sel_t idx
  );
    logic [NCH-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/demux_ptr.sv
// Wrap-around scan pointer for demux_4.
// Priority: rst > clr > load > inc.
module demux_ptr
  import demux_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  sel_t ld_val,
  input  logic inc,
  output sel_t cur_ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_ptr <= '0;
    end else if (clr) begin
      cur_ptr <= '0;
    end else if (load) begin
      cur_ptr <= ld_val;
    end else if (inc) begin
      cur_ptr <= cur_ptr + 2'd1;
    end
  end

endmodule

// File: rtl/demux_4.sv
// Registered 1-to-4 demultiplexer with manual select or auto scan.
// Outputs hold between writes; upd/frame are one-cycle strobes.
module demux_4
  import demux_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic         auto,
  input  logic [1:0]   sel,
  input  logic         din_valid,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout0,
  output logic [W-1:0] dout1,
  output logic [W-1:0] dout2,
  output logic [W-1:0] dout3,
  output logic [3:0]   upd,
  output logic [1:0]   cur_ptr,
  output logic         frame
);

  logic         acc;
  sel_t         tgt;
  sel_t         ptr;
  logic [W-1:0] ch [NCH];

  assign acc = en & din_valid & ~clr & ~rst;
  assign tgt = auto ? ptr : sel_t'(sel);

  // Manual writes reload the pointer so a later switch to auto
  // continues with the channel after the last one written.
  demux_ptr u_ptr (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .load    (acc & ~auto),
    .ld_val  (sel_t'(sel) + 2'd1),
    .inc     (acc & auto),
    .cur_ptr (ptr)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int k = 0; k < NCH; k++) begin
        ch[k] <= '0;
      end
      upd   <= '0;
      frame <= 1'b0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (acc && (tgt == sel_t'(k))) begin
          ch[k] <= din;
        end
      end
      upd   <= acc ? onehot(tgt) : 4'b0000;
      frame <= acc & auto & (ptr == 2'd3);
    end
  end

  assign dout0   = ch[0];
  assign dout1   = ch[1];
  assign dout2   = ch[2];
  assign dout3   = ch[3];
  assign cur_ptr = ptr;

endmodule

// File: tb/tb_demux_4.sv
// Scoreboard bench for demux_4: driver queues hand-computed
// expected outputs, a monitor pops and compares after each edge.
module tb_demux_4;

  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         clr;
  logic         auto;
  logic [1:0]   sel;
  logic         din_valid;
  logic [W-1:0] din;
  logic [W-1:0] dout0, dout1, dout2, dout3;
  logic [3:0]   upd;
  logic [1:0]   cur_ptr;
  logic         frame;

  typedef struct packed {
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    logic [W-1:0] d3;
    logic [3:0]   upd;
    logic [1:0]   ptr;
    logic         frame;
  } exp_t;

  exp_t q[$];
  int   applied = 0;
  int   miscompares = 0;
  int   vec_id = 0;
  int   mon_id = 0;

  always #5 clk = ~clk;

  demux_4 #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .auto      (auto),
    .sel       (sel),
    .din_valid (din_valid),
    .din       (din),
    .dout0     (dout0),
    .dout1     (dout1),
    .dout2     (dout2),
    .dout3     (dout3),
    .upd       (upd),
    .cur_ptr   (cur_ptr),
    .frame     (frame)
  );

  // Monitor: sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = q.pop_front();
      a = '{dout0, dout1, dout2, dout3, upd, cur_ptr, frame};
      applied++;
      mon_id++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL vec%0d: got d=%h,%h,%h,%h upd=%b ptr=%0d fr=%b exp d=%h,%h,%h,%h upd=%b ptr=%0d fr=%b",
          mon_id, a.d0, a.d1, a.d2, a.d3, a.upd, a.ptr, a.frame,
          e.d0, e.d1, e.d2, e.d3, e.upd, e.ptr, e.frame);
      end
    end
  end

  task automatic step(
    input logic         r,
    input logic         e_n,
    input logic         c,
    input logic         au,
    input logic [1:0]   s,
    input logic         dv,
    input logic [W-1:0] d,
    input logic [W-1:0] x0,
    input logic [W-1:0] x1,
    input logic [W-1:0] x2,
    input logic [W-1:0] x3,
    input logic [3:0]   xu,
    input logic [1:0]   xp,
    input logic         xf
  );
    @(posedge clk);
    #2;
    rst = r; en = e_n; clr = c; auto = au;
    sel = s; din_valid = dv; din = d;
    q.push_back('{x0, x1, x2, x3, xu, xp, xf});
    vec_id++;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; auto = 1'b0;
    sel = 2'd0; din_valid = 1'b0; din = '0;
    //   rst en clr au sel dv din | d0 d1 d2 d3 upd   ptr fr
    step(1, 1, 0, 0, 0, 1, 3,   0, 0, 0, 0, 4'b0000, 0, 0);
    step(1, 1, 0, 0, 0, 1, 3,   0, 0, 0, 0, 4'b0000, 0, 0);
    step(0, 1, 0, 0, 2, 1, 1,   0, 0, 1, 0, 4'b0100, 3, 0);
    step(0, 1, 0, 0, 0, 1, 3,   3, 0, 1, 0, 4'b0001, 1, 0);
    step(0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 4'b0000, 0, 0);
    step(0, 1, 0, 1, 0, 1, 0,   0, 0, 0, 0, 4'b0001, 1, 0);
    step(0, 1, 0, 1, 0, 1, 1,   0, 1, 0, 0, 4'b0010, 2, 0);
    step(0, 1, 0, 1, 0, 1, 2,   0, 1, 2, 0, 4'b0100, 3, 0);
    step(0, 1, 0, 1, 0, 1, 3,   0, 1, 2, 3, 4'b1000, 0, 1);
    step(0, 1, 0, 1, 0, 1, 1,   1, 1, 2, 3, 4'b0001, 1, 0);
    step(0, 1, 0, 1, 0, 0, 0,   1, 1, 2, 3, 4'b0000, 1, 0);
    step(0, 0, 0, 1, 0, 1, 2,   1, 1, 2, 3, 4'b0000, 1, 0);
    step(0, 0, 0, 1, 0, 1, 2,   1, 1, 2, 3, 4'b0000, 1, 0);
    step(0, 0, 0, 1, 0, 1, 2,   1, 1, 2, 3, 4'b0000, 1, 0);
    step(0, 1, 0, 1, 0, 1, 0,   1, 0, 2, 3, 4'b0010, 2, 0);
    step(0, 1, 1, 1, 0, 1, 3,   0, 0, 0, 0, 4'b0000, 0, 0);
    step(0, 1, 0, 1, 0, 1, 2,   2, 0, 0, 0, 4'b0001, 1, 0);
    step(0, 1, 0, 0, 1, 1, 1,   2, 1, 0, 0, 4'b0010, 2, 0);
    step(0, 1, 0, 1, 0, 1, 2,   2, 1, 2, 0, 4'b0100, 3, 0);
    step(0, 1, 0, 0, 3, 1, 3,   2, 1, 2, 3, 4'b1000, 0, 0);
    step(0, 1, 0, 1, 0, 1, 1,   1, 1, 2, 3, 4'b0001, 1, 0);
    step(0, 1, 0, 1, 0, 1, 3,   1, 3, 2, 3, 4'b0010, 2, 0);
    step(1, 1, 0, 1, 0, 1, 3,   0, 0, 0, 0, 4'b0000, 0, 0);
    step(0, 1, 0, 1, 0, 1, 3,   3, 0, 0, 0, 4'b0001, 1, 0);
    step(0, 1, 0, 1, 2, 0, 1,   3, 0, 0, 0, 4'b0000, 1, 0);
    @(posedge clk);
    #2;
    din_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(posedge clk);
    end
    #3;
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    if (applied != vec_id) begin
      miscompares++;
      $display("FAIL count: checked %0d, expected %0d", applied, vec_id);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
      applied, miscompares);
    $finish;
  end

endmodule
